// File: rtl/rv32i_types.sv
// Shared types for the branch predictor: BTB entry, PHT counter, EX update bundle.
// No ports; imported by brp_sat_ctr and brp_bimodal_btb.
package rv32i_types;

   // Widest tag any legal ENTRIES/TAG_BITS pair can need (32 - 2 - log2(4)).
   localparam int BRP_TAG_MAX = 28;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } brp_ctr_t;

   typedef struct packed {
      logic                   valid;
      logic                   jal;
      logic [BRP_TAG_MAX-1:0] tag;
      logic [31:0]            target;
   } brp_btb_entry_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        is_br;
      logic        is_jal;
      logic        taken;
      logic [31:0] target;
      logic        mispredict;
   } brp_upd_t;

endpackage

// File: rtl/brp_sat_ctr.sv
// 2-bit saturating counter next-state function for PHT entries.
// Ports: ctr (current state), inc (taken), nxt (next state).
module brp_sat_ctr
   import rv32i_types::*;
(
   input  brp_ctr_t ctr,
   input  logic     inc,
   output brp_ctr_t nxt
);

   always_comb begin
      nxt = ctr;
      unique case (ctr)
         SNT: nxt = inc ? WNT : SNT;
         WNT: nxt = inc ? WT  : SNT;
         WT:  nxt = inc ? ST  : WNT;
         ST:  nxt = inc ? ST  : WT;
      endcase
   end

endmodule

// File: rtl/brp_bimodal_btb.sv
// Dynamic branch predictor: 2-bit PHT (bimodal or gshare index) plus tagged BTB.
// Ports: clk, rst (async active-low), stall; lookup_pc -> pred_hit/taken/target
// (combinational); upd_* train from EX; stat_* counters when BRP_STATS_EN is
// defined, otherwise tied to 0.
module brp_bimodal_btb
   import rv32i_types::*;
#(
   parameter int ENTRIES  = 64,
   parameter int TAG_BITS = 8,
   parameter int GSHARE   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] lookup_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_br,
   input  logic        upd_is_jal,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispredict,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);

   localparam int IDX = $clog2(ENTRIES);

   function automatic logic [BRP_TAG_MAX-1:0] tag_of(input logic [31:0] pc);
      logic [31:0] mask;
      mask = (32'd1 << TAG_BITS) - 32'd1;
      return BRP_TAG_MAX'((pc >> (IDX + 2)) & mask);
   endfunction

   brp_btb_entry_t btb [ENTRIES];
   brp_ctr_t       pht [ENTRIES];
   logic [IDX-1:0] ghr;

   brp_upd_t upd;

   assign upd.valid      = upd_valid;
   assign upd.pc         = upd_pc;
   assign upd.is_br      = upd_is_br;
   assign upd.is_jal     = upd_is_jal;
   assign upd.taken      = upd_taken;
   assign upd.target     = upd_target;
   assign upd.mispredict = upd_mispredict;

   // Lookup path
   logic [IDX-1:0] lk_bidx;
   logic [IDX-1:0] lk_pidx;
   brp_btb_entry_t lk_ent;
   brp_ctr_t       lk_ctr;

   assign lk_bidx = lookup_pc[IDX+1:2];
   assign lk_pidx = (GSHARE != 0) ? (lk_bidx ^ ghr) : lk_bidx;
   assign lk_ent  = btb[lk_bidx];
   assign lk_ctr  = pht[lk_pidx];

   assign pred_hit    = lk_ent.valid && (lk_ent.tag == tag_of(lookup_pc));
   assign pred_taken  = pred_hit && (lk_ent.jal || lk_ctr[1]);
   assign pred_target = pred_hit ? lk_ent.target : 32'd0;

   // Training path
   logic [IDX-1:0] up_bidx;
   logic [IDX-1:0] up_pidx;
   brp_ctr_t       up_cur;
   brp_ctr_t       up_nxt;
   logic           train;
   logic           wr_pht;
   logic           wr_btb;

   assign up_bidx = upd.pc[IDX+1:2];
   assign up_pidx = (GSHARE != 0) ? (up_bidx ^ ghr) : up_bidx;
   assign up_cur  = pht[up_pidx];

   assign train  = upd.valid && !stall;
   assign wr_pht = train && upd.is_br;
   // Not-taken branches leave the BTB alone so a jal/taken entry survives.
   assign wr_btb = train && ((upd.is_br && upd.taken) || upd.is_jal);

   brp_sat_ctr u_sat_ctr (
      .ctr (up_cur),
      .inc (upd.taken),
      .nxt (up_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb[i] <= '0;
            pht[i] <= WNT;
         end
         ghr <= '0;
      end else begin
         if (wr_pht) begin
            pht[up_pidx] <= up_nxt;
         end
         if (wr_pht && (GSHARE != 0)) begin
            ghr <= {ghr[IDX-2:0], upd.taken};
         end
         if (wr_btb) begin
            btb[up_bidx] <= '{
               valid:  1'b1,
               jal:    upd.is_jal,
               tag:    tag_of(upd.pc),
               target: upd.target
            };
         end
      end
   end

`ifdef BRP_STATS_EN
   logic [31:0] br_cnt;
   logic [31:0] mp_cnt;
   logic        cf_upd;

   assign cf_upd = train && (upd.is_br || upd.is_jal);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         br_cnt <= '0;
         mp_cnt <= '0;
      end else if (cf_upd) begin
         if (br_cnt != '1) begin
            br_cnt <= br_cnt + 32'd1;
         end
         if (upd.mispredict && (mp_cnt != '1)) begin
            mp_cnt <= mp_cnt + 32'd1;
         end
      end
   end

   assign stat_branches    = br_cnt;
   assign stat_mispredicts = mp_cnt;

   logic unused_bits;
   assign unused_bits = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};
`else
   assign stat_branches    = 32'd0;
   assign stat_mispredicts = 32'd0;

   logic unused_bits;
   assign unused_bits = &{1'b0, lookup_pc[1:0], upd_pc[1:0],
                          upd.mispredict};
`endif

endmodule

// File: tb/tb_brp_bimodal_btb.sv
// Directed bench for brp_bimodal_btb: bimodal instance plus a gshare instance
// sharing the same stimulus; expected predictions go through a scoreboard queue.
module tb_brp_bimodal_btb;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [31:0] lookup_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_is_br;
   logic        upd_is_jal;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispredict;

   logic        b_hit, b_taken;
   logic [31:0] b_target, b_sbr, b_smp;
   logic        g_hit, g_taken;
   logic [31:0] g_target, g_sbr, g_smp;

   always #5 clk = ~clk;

   brp_bimodal_btb #(.ENTRIES(64), .TAG_BITS(8), .GSHARE(0)) u_bim (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .lookup_pc        (lookup_pc),
      .pred_hit         (b_hit),
      .pred_taken       (b_taken),
      .pred_target      (b_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_is_br        (upd_is_br),
      .upd_is_jal       (upd_is_jal),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_mispredict   (upd_mispredict),
      .stat_branches    (b_sbr),
      .stat_mispredicts (b_smp)
   );

   brp_bimodal_btb #(.ENTRIES(64), .TAG_BITS(8), .GSHARE(1)) u_gsh (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .lookup_pc        (lookup_pc),
      .pred_hit         (g_hit),
      .pred_taken       (g_taken),
      .pred_target      (g_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_is_br        (upd_is_br),
      .upd_is_jal       (upd_is_jal),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_mispredict   (upd_mispredict),
      .stat_branches    (g_sbr),
      .stat_mispredicts (g_smp)
   );

   typedef struct {
      string       tag;
      bit          gsh;
      logic        hit;
      logic        taken;
      logic [31:0] target;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] stat(input int v);
`ifdef BRP_STATS_EN
      return 32'(v);
`else
      return 32'd0 + 32'(v & 0);
`endif
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input bit gsh, input logic h,
                       input logic t, input logic [31:0] tg);
      exp_t e;
      e.tag = tag;
      e.gsh = gsh;
      e.hit = h;
      e.taken = t;
      e.target = tg;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.gsh) begin
            cmp({e.tag, "_g_hit"}, 32'(g_hit), 32'(e.hit));
            cmp({e.tag, "_g_taken"}, 32'(g_taken), 32'(e.taken));
            cmp({e.tag, "_g_target"}, g_target, e.target);
         end else begin
            cmp({e.tag, "_hit"}, 32'(b_hit), 32'(e.hit));
            cmp({e.tag, "_taken"}, 32'(b_taken), 32'(e.taken));
            cmp({e.tag, "_target"}, b_target, e.target);
         end
      end
   endtask

   task automatic look(input logic [31:0] pc, input string tag,
                       input logic h, input logic t,
                       input logic [31:0] tg);
      lookup_pc = pc;
      push(tag, 1'b0, h, t, tg);
      drain();
   endtask

   task automatic look2(input logic [31:0] pc, input string tag,
                        input logic h, input logic t, input logic [31:0] tg,
                        input logic gh, input logic gt,
                        input logic [31:0] gtg);
      lookup_pc = pc;
      push(tag, 1'b0, h, t, tg);
      push(tag, 1'b1, gh, gt, gtg);
      drain();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic br,
                          input logic jal, input logic tk,
                          input logic [31:0] tgt, input logic mis);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_is_br      = br;
      upd_is_jal     = jal;
      upd_taken      = tk;
      upd_target     = tgt;
      upd_mispredict = mis;
   endtask

   task automatic clr_upd();
      upd_valid      = 1'b0;
      upd_is_br      = 1'b0;
      upd_is_jal     = 1'b0;
      upd_taken      = 1'b0;
      upd_mispredict = 1'b0;
   endtask

   task automatic train(input logic [31:0] pc, input logic br,
                        input logic jal, input logic tk,
                        input logic [31:0] tgt, input logic mis);
      set_upd(pc, br, jal, tk, tgt, mis);
      tick();
      clr_upd();
   endtask

   task automatic stats(input string tag, input int br, input int mp);
      cmp({tag, "_stat_br"}, b_sbr, stat(br));
      cmp({tag, "_stat_mp"}, b_smp, stat(mp));
   endtask

   initial begin
      rst = 1'b0;
      stall = 1'b0;
      lookup_pc = 32'h0;
      upd_pc = 32'h0;
      upd_target = 32'h0;
      clr_upd();

      // Reset state
      look2(32'h60, "reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      stats("reset", 0, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // First taken branch; lookup in the same cycle sees old state
      set_upd(32'h80, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
      look(32'h80, "same_cycle", 1'b0, 1'b0, 32'h0);
      tick();
      clr_upd();
      look2(32'h80, "bim_first", 1'b1, 1'b1, 32'h40,
            1'b1, 1'b0, 32'h40);
      stats("first", 1, 1);

      // Saturation: WT -> ST, then two not-taken
      repeat (4) train(32'h80, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
      train(32'h80, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      look(32'h80, "st_to_wt", 1'b1, 1'b1, 32'h40);
      train(32'h80, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      look(32'h80, "wt_to_wnt", 1'b1, 1'b0, 32'h40);

      // Neither branch nor jal: nothing changes
      train(32'h80, 1'b0, 1'b0, 1'b1, 32'h99, 1'b1);
      look(32'h80, "noop", 1'b1, 1'b0, 32'h40);
      stats("noop", 7, 1);

      // Stall holds training off for three edges
      set_upd(32'h80, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
      stall = 1'b1;
      repeat (3) tick();
      look(32'h80, "stalled", 1'b1, 1'b0, 32'h40);
      stats("stalled", 7, 1);
      stall = 1'b0;
      tick();
      clr_upd();
      look(32'h80, "unstalled", 1'b1, 1'b1, 32'h40);
      stats("unstalled", 8, 2);

      // Aliasing at index 32
      look(32'h180, "alias_miss", 1'b0, 1'b0, 32'h0);
      train(32'h180, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
      look(32'h80, "alias_evict", 1'b0, 1'b0, 32'h0);
      look(32'h180, "jal_hit", 1'b1, 1'b1, 32'h200);
      train(32'h180, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      look(32'h183, "nt_keeps_btb", 1'b1, 1'b1, 32'h200);
      stats("alias", 10, 3);

      // Async reset between edges
      train(32'h80, 1'b1, 1'b0, 1'b1, 32'h44, 1'b0);
      look(32'h80, "pre_reset", 1'b1, 1'b1, 32'h44);
      #2;
      rst = 1'b0;
      look2(32'h80, "async_rst", 1'b0, 1'b0, 32'h0,
            1'b0, 1'b0, 32'h0);
      stats("async_rst", 0, 0);
      #2;
      rst = 1'b1;
      tick();

      // ghr must restart at 0: train at ghr=0, then six not-taken
      // branches shift it back to 0 without touching PHT[32].
      train(32'h80, 1'b1, 1'b0, 1'b1, 32'h48, 1'b0);
      repeat (6) train(32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      look2(32'h80, "ghr_cleared", 1'b1, 1'b1, 32'h48,
            1'b1, 1'b1, 32'h48);
      stats("post_reset", 7, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
